// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT front end.
// Frame buffer state and sample word definitions.
package fft_pkg;

  localparam int WIDTH     = 18;
  localparam int N         = 256;
  localparam int ADC_WIDTH = 12;

  typedef logic [WIDTH-1:0] sample_t;

  typedef enum logic {
    FILLING,
    FILLING_BUSY
  } fb_state_t;

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample stream in, frame bus and FFT handshake out.
// master drives samples/done, slave is the framer.
interface fft_frame_buffer_if #(
  parameter int WIDTH     = 18,
  parameter int N         = 256,
  parameter int ADC_WIDTH = 12
) ();

  logic [ADC_WIDTH-1:0] sample_in;
  logic                 sample_valid;
  logic                 done;
  logic                 start;
  logic [WIDTH-1:0]     time_samples [N];
  logic                 fft_busy;
  logic                 overrun;
  logic [15:0]          frames_dropped;

  modport master (
    output sample_in,
    output sample_valid,
    output done,
    input  start,
    input  time_samples,
    input  fft_busy,
    input  overrun,
    input  frames_dropped
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    input  done,
    output start,
    output time_samples,
    output fft_busy,
    output overrun,
    output frames_dropped
  );

endinterface

// File: rtl/sample_bank.sv
// One frame bank: single write port, sync clear,
// every word visible in parallel.
module sample_bank #(
  parameter int WIDTH = 18,
  parameter int N     = 256,
  parameter int AW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata [N]
);

  logic [WIDTH-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q;

endmodule

// File: rtl/fft_frame_buffer.sv
// Double-buffered 256-point framer in front of fft_256.
// Fills one bank while the FFT holds the other.
module fft_frame_buffer #(
  parameter int WIDTH     = fft_pkg::WIDTH,
  parameter int N         = fft_pkg::N,
  parameter int ADC_WIDTH = fft_pkg::ADC_WIDTH,
  parameter bit REMOVE_DC = 1'b0
) (
  input logic              clk,
  input logic              rst,
  fft_frame_buffer_if.slave bus
);

  import fft_pkg::*;

  localparam int AW = $clog2(N);

  fb_state_t        state_q;
  logic             wr_sel_q;
  logic [AW-1:0]    wr_idx_q;
  logic             start_q;
  logic             overrun_q;
  logic [15:0]      dropped_q;

  logic             clr;
  logic             frame_done;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_a [N];
  logic [WIDTH-1:0] rd_b [N];

  assign clr        = !rst;
  assign frame_done = bus.sample_valid
                   && (wr_idx_q == AW'(N - 1));

  // Offset binary to two's complement is an MSB flip.
  if (REMOVE_DC) begin : g_dc
    assign wdata = {
      {(WIDTH - ADC_WIDTH + 1){~bus.sample_in[ADC_WIDTH-1]}},
      bus.sample_in[ADC_WIDTH-2:0]
    };
  end else begin : g_raw
    assign wdata = {
      {(WIDTH - ADC_WIDTH){1'b0}},
      bus.sample_in
    };
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FILLING;
      wr_sel_q  <= 1'b0;
      wr_idx_q  <= '0;
      start_q   <= 1'b0;
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      start_q <= 1'b0;
      if (bus.sample_valid) begin
        wr_idx_q <= wr_idx_q + 1'b1;
      end
      unique case (state_q)
        FILLING: begin
          if (frame_done) begin
            wr_sel_q <= ~wr_sel_q;
            start_q  <= 1'b1;
            state_q  <= FILLING_BUSY;
          end
        end
        FILLING_BUSY: begin
          // done frees the read bank before the swap check.
          unique case (1'b1)
            bus.done && frame_done: begin
              wr_sel_q <= ~wr_sel_q;
              start_q  <= 1'b1;
            end
            bus.done && !frame_done: begin
              state_q <= FILLING;
            end
            !bus.done && frame_done: begin
              overrun_q <= 1'b1;
              if (dropped_q != 16'hFFFF) begin
                dropped_q <= dropped_q + 16'd1;
              end
            end
            default: ;
          endcase
        end
        default: state_q <= FILLING;
      endcase
    end
  end

  sample_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank_a (
    .clk   (clk),
    .clr   (clr),
    .we    (bus.sample_valid && !wr_sel_q),
    .addr  (wr_idx_q),
    .wdata (wdata),
    .rdata (rd_a)
  );

  sample_bank #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_bank_b (
    .clk   (clk),
    .clr   (clr),
    .we    (bus.sample_valid && wr_sel_q),
    .addr  (wr_idx_q),
    .wdata (wdata),
    .rdata (rd_b)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.time_samples[i] = wr_sel_q ? rd_a[i] : rd_b[i];
    end
  end

  assign bus.start          = start_q;
  assign bus.fft_busy       = (state_q == FILLING_BUSY);
  assign bus.overrun        = overrun_q;
  assign bus.frames_dropped = dropped_q;

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Bench for fft_frame_buffer: frame-level model,
// directed corner sequences and random traffic.
module tb_fft_frame_buffer;

  import fft_pkg::*;

  localparam int W  = 18;
  localparam int NN = 256;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fft_frame_buffer_if #(.WIDTH(W), .N(NN), .ADC_WIDTH(AW)) bus0 ();
  fft_frame_buffer_if #(.WIDTH(W), .N(NN), .ADC_WIDTH(AW)) bus1 ();

  fft_frame_buffer #(
    .WIDTH(W), .N(NN), .ADC_WIDTH(AW), .REMOVE_DC(1'b0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  fft_frame_buffer #(
    .WIDTH(W), .N(NN), .ADC_WIDTH(AW), .REMOVE_DC(1'b1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference: a list of pending samples and
  // a snapshot of the last frame handed to the FFT.
  logic [AW-1:0] m_frame [NN];
  logic [AW-1:0] m_read  [NN];
  bit            m_zero;
  int            m_cnt;
  bit            m_busy;
  bit            m_ovr;
  bit            m_start;
  int            m_drop;

  typedef struct {
    logic [AW-1:0] s;
    logic [W-1:0]  exp_raw;
    logic [W-1:0]  exp_dc;
  } conv_vec_t;

  conv_vec_t tbl [5];

  function automatic logic [W-1:0] conv(logic [AW-1:0] s, bit dc);
    int v;
    v = int'(s);
    if (dc) v = v - 2048;
    return W'(v);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(bit v, logic [AW-1:0] s, bit d);
    if (!rst) begin
      m_cnt   = 0;
      m_busy  = 0;
      m_ovr   = 0;
      m_start = 0;
      m_drop  = 0;
      m_zero  = 1;
      return;
    end
    m_start = 0;
    if (d && m_busy) m_busy = 0;
    if (v) begin
      m_frame[m_cnt] = s;
      m_cnt++;
      if (m_cnt == NN) begin
        m_cnt = 0;
        if (!m_busy) begin
          m_read  = m_frame;
          m_zero  = 0;
          m_busy  = 1;
          m_start = 1;
        end else begin
          m_ovr = 1;
          if (m_drop < 65535) m_drop++;
        end
      end
    end
  endtask

  task automatic cmp_ts();
    int bad0;
    int bad1;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    bad0 = -1;
    bad1 = -1;
    for (int i = 0; i < NN; i++) begin
      e0 = m_zero ? '0 : conv(m_read[i], 0);
      e1 = m_zero ? '0 : conv(m_read[i], 1);
      if (bad0 < 0 && bus0.time_samples[i] !== e0) bad0 = i;
      if (bad1 < 0 && bus1.time_samples[i] !== e1) bad1 = i;
    end
    checks += 2;
    if (bad0 >= 0) begin
      errors++;
      $display("FAIL ts_raw[%0d]: got %h expected %h", bad0,
               bus0.time_samples[bad0],
               m_zero ? 18'h0 : conv(m_read[bad0], 0));
    end
    if (bad1 >= 0) begin
      errors++;
      $display("FAIL ts_dc[%0d]: got %h expected %h", bad1,
               bus1.time_samples[bad1],
               m_zero ? 18'h0 : conv(m_read[bad1], 1));
    end
  endtask

  task automatic cmp_all();
    chk("start0", int'(bus0.start), int'(m_start));
    chk("busy0", int'(bus0.fft_busy), int'(m_busy));
    chk("ovr0", int'(bus0.overrun), int'(m_ovr));
    chk("drop0", int'(bus0.frames_dropped), m_drop);
    chk("start1", int'(bus1.start), int'(m_start));
    chk("busy1", int'(bus1.fft_busy), int'(m_busy));
    chk("ovr1", int'(bus1.overrun), int'(m_ovr));
    chk("drop1", int'(bus1.frames_dropped), m_drop);
    cmp_ts();
  endtask

  task automatic cyc(bit v, logic [AW-1:0] s, bit d);
    bus0.sample_valid = v;
    bus0.sample_in    = s;
    bus0.done         = d;
    bus1.sample_valid = v;
    bus1.sample_in    = s;
    bus1.done         = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    cmp_all();
  endtask

  task automatic do_reset(int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) cyc(0, '0, 0);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = '{s: 12'd0,    exp_raw: 18'd0,    exp_dc: 18'h3F800};
    tbl[1] = '{s: 12'd2048, exp_raw: 18'd2048, exp_dc: 18'h00000};
    tbl[2] = '{s: 12'd4095, exp_raw: 18'd4095, exp_dc: 18'h007FF};
    tbl[3] = '{s: 12'd1,    exp_raw: 18'd1,    exp_dc: 18'h3F801};
    tbl[4] = '{s: 12'd2047, exp_raw: 18'd2047, exp_dc: 18'h3FFFF};

    for (int i = 0; i < NN; i++) begin
      m_frame[i] = '0;
      m_read[i]  = '0;
    end

    // Reset
    do_reset(2);
    chk("rst_ts0", int'(bus0.time_samples[0]), 0);
    chk("rst_ts255", int'(bus1.time_samples[255]), 0);

    // Single frame, value = index
    for (int i = 0; i < NN; i++) begin
      chk("sf_nostart", int'(bus0.start), 0);
      cyc(1, AW'(i), 0);
    end
    chk("sf_start", int'(bus0.start), 1);
    chk("sf_busy", int'(bus0.fft_busy), 1);
    chk("sf_ts200", int'(bus0.time_samples[200]), 200);
    cyc(0, '0, 0);
    chk("sf_start_low", int'(bus0.start), 0);

    // Release, then a frame led by the conversion vectors
    cyc(0, '0, 1);
    chk("rel_busy", int'(bus0.fft_busy), 0);
    for (int i = 0; i < NN; i++) begin
      cyc(1, (i < 5) ? tbl[i].s : AW'(i), 0);
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("conv_raw%0d", k),
          int'(bus0.time_samples[k]), int'(tbl[k].exp_raw));
      chk($sformatf("conv_dc%0d", k),
          int'(bus1.time_samples[k]), int'(tbl[k].exp_dc));
    end

    // Overrun: two frames while FFT holds the bank
    for (int i = 0; i < 2 * NN; i++) begin
      cyc(1, AW'($urandom), 0);
    end
    chk("ovr_flag", int'(bus0.overrun), 1);
    chk("ovr_cnt", int'(bus0.frames_dropped), 2);
    chk("ovr_hold", int'(bus1.time_samples[0]), 'h3F800);
    cyc(0, '0, 1);
    for (int i = 0; i < NN; i++) cyc(1, AW'($urandom), 0);
    chk("ovr_restart", int'(bus0.start), 1);

    // done together with the 256th sample
    for (int i = 0; i < NN - 1; i++) cyc(1, AW'(i + 7), 0);
    cyc(1, AW'(99), 1);
    chk("sim_start", int'(bus0.start), 1);
    chk("sim_nodrop", int'(bus0.frames_dropped), 2);
    chk("sim_ts255", int'(bus0.time_samples[255]), 99);

    // Reset mid-frame, stale done ignored
    for (int i = 0; i < 100; i++) cyc(1, AW'(i), 0);
    do_reset(2);
    cyc(0, '0, 1);
    chk("mid_busy", int'(bus0.fft_busy), 0);
    for (int i = 0; i < NN - 1; i++) cyc(1, AW'(i * 3), 0);
    chk("mid_nostart", int'(bus0.start), 0);
    cyc(1, AW'(5), 0);
    chk("mid_start", int'(bus0.start), 1);
    chk("mid_ovr", int'(bus0.overrun), 0);

    // Random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 1999) == 0) begin
        do_reset(1);
      end else begin
        cyc(($urandom % 4) != 0, AW'($urandom),
            ($urandom % 150) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
